// File: rtl/gb_serial.sv
// gb_serial: link-port serial controller with the SB data register (0xFF01),
// the SC control register (0xFF02), an 8-bit MSB-first shifter, an internal
// clock divider and a synchronizer for an external serial clock.
module gb_serial #(
  parameter int CLK_DIV = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        wr_en,
  output logic [7:0]  data_o,
  output logic        data_oe,
  output logic        irq_serial,
  output logic        sout,
  input  logic        sin,
  output logic        sclk_o,
  input  logic        sclk_i
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_M1 = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [7:0]       sb_r;
  logic             sc7_r;
  logic             sc0_r;
  logic [2:0]       bit_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       sync_r;
  logic             sync_prev_r;

  logic sel_sb_s;
  logic sel_sc_s;
  logic wr_sb_s;
  logic wr_sc_s;
  logic ext_fall_s;
  logic ext_rise_s;
  logic fall_s;
  logic rise_s;
  logic done_s;
  logic start_s;
  logic abort_s;

  // Decode CPU accesses, derive shift-clock events and the next FSM state.
  always_comb begin
    sel_sb_s   = (addr_i == 16'hFF01);
    sel_sc_s   = (addr_i == 16'hFF02);
    wr_sb_s    = wr_en & sel_sb_s;
    wr_sc_s    = wr_en & sel_sc_s;
    ext_fall_s = sync_prev_r & ~sync_r[1];
    ext_rise_s = ~sync_prev_r & sync_r[1];
    fall_s     = 1'b0;
    rise_s     = 1'b0;
    if (state_r == SHIFT) begin
      if (sc0_r) begin
        fall_s = (div_r == HALF_M1);
        rise_s = (div_r == FULL_M1);
      end else begin
        fall_s = ext_fall_s;
        rise_s = ext_rise_s;
      end
    end else begin
      fall_s = 1'b0;
      rise_s = 1'b0;
    end
    // The eighth shift takes priority over a simultaneous abort write.
    done_s  = rise_s & (bit_cnt_r == 3'd7);
    start_s = (state_r == IDLE) & wr_sc_s & data_i[7];
    abort_s = (state_r == SHIFT) & wr_sc_s & ~data_i[7] & ~done_s;
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = SHIFT;
        else         state_s = IDLE;
      end
      SHIFT: begin
        if (done_s || abort_s) state_s = IDLE;
        else                   state_s = SHIFT;
      end
      default: state_s = IDLE;
    endcase
  end

  // Read mux: register contents are visible combinationally (pre-edge values).
  always_comb begin
    data_o  = 8'hFF;
    data_oe = 1'b0;
    if (sel_sb_s) begin
      data_o  = sb_r;
      data_oe = 1'b1;
    end else if (sel_sc_s) begin
      data_o  = {sc7_r, 6'b111111, sc0_r};
      data_oe = 1'b1;
    end else begin
      data_o  = 8'hFF;
      data_oe = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Two-flop synchronizer for sclk_i plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r      <= 2'b11;
      sync_prev_r <= 1'b1;
    end else begin
      sync_r      <= {sync_r[0], sclk_i};
      sync_prev_r <= sync_r[1];
    end
  end

  // Registers, divider, bit counter, serial pins and the completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_r       <= 8'h00;
      sc7_r      <= 1'b0;
      sc0_r      <= 1'b0;
      bit_cnt_r  <= 3'd0;
      div_r      <= DIV_ZERO;
      sclk_o     <= 1'b1;
      sout       <= 1'b1;
      irq_serial <= 1'b0;
    end else begin
      irq_serial <= done_s;
      if (start_s) begin
        sc0_r     <= data_i[0];
        sc7_r     <= 1'b1;
        bit_cnt_r <= 3'd0;
        div_r     <= DIV_ZERO;
        sclk_o    <= 1'b1;
      end else if (state_r == IDLE) begin
        if (wr_sb_s) sb_r  <= data_i;
        if (wr_sc_s) sc0_r <= data_i[0];
      end else if (abort_s) begin
        // Abort keeps the partially shifted SB and parks the clock high.
        sc7_r     <= 1'b0;
        sc0_r     <= data_i[0];
        sclk_o    <= 1'b1;
        div_r     <= DIV_ZERO;
        bit_cnt_r <= 3'd0;
      end else begin
        if (div_r == FULL_M1) div_r <= DIV_ZERO;
        else                  div_r <= div_r + DIV_ONE;
        if (fall_s) begin
          sout   <= sb_r[7];
          sclk_o <= ~sc0_r;
        end
        if (rise_s) begin
          sb_r      <= {sb_r[6:0], sin};
          bit_cnt_r <= bit_cnt_r + 3'd1;
          sclk_o    <= 1'b1;
        end
        if (done_s) sc7_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gb_serial.md
GB_SERIAL -- requirements
Module: gb_serial

Interface
REQ-001 SHALL have parameter CLK_DIV, default 512, meaning system clocks per serial bit for the internal clock (even, >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr_i  input  16  CPU address bus.
REQ-005 SHALL have port data_i  input  8  CPU write data.
REQ-006 SHALL have port wr_en  input  1  CPU write strobe (CPU drive_data_bus), sampled at clk edge.
REQ-007 SHALL have port data_o  output  8  read data for the selected register.
REQ-008 SHALL have port data_oe  output  1  high when addr_i is 0xFF01 or 0xFF02.
REQ-009 SHALL have port irq_serial  output  1  one-cycle request to set IF bit 3.
REQ-010 SHALL have port sout  output  1  serial data out.
REQ-011 SHALL have port sin  input  1  serial data in.
REQ-012 SHALL have port sclk_o  output  1  serial clock driven in internal-clock mode.
REQ-013 SHALL have port sclk_i  input  1  external serial clock, asynchronous.

Function
REQ-014 SHALL implement SB at 0xFF01 (8-bit shift register) and SC at 0xFF02 (bit7 = transfer active, bit0 = clock select, 1 = internal).
REQ-015 SHALL drive data_o combinationally: 0xFF01 -> SB; 0xFF02 -> {SC7, 6'b111111, SC0}; otherwise 0xFF with data_oe low.
REQ-016 SHALL use states IDLE and SHIFT, plus a 3-bit bit counter and a divider counter.
REQ-017 In IDLE, a write to SC with data_i[7]=1 SHALL latch SC0, set SC7, clear bit counter and divider, and enter SHIFT at that edge (E0).
REQ-018 In IDLE, writes to SB SHALL load SB; writes to SC with data_i[7]=0 SHALL update SC0 only.
REQ-019 Internal mode: sclk_o SHALL go low at E0+CLK_DIV/2 and high at E0+CLK_DIV, repeating every CLK_DIV clocks for 8 bit periods.
REQ-020 On each sclk_o falling edge, sout SHALL take SB[7]; on each rising edge, SB SHALL become {SB[6:0], sin} and the bit counter SHALL increment.
REQ-021 External mode: sclk_i SHALL pass through a 2-flop synchronizer; synchronized falling/rising edges SHALL act as in REQ-020; sclk_o SHALL stay high.
REQ-022 At the edge performing the 8th shift, the block SHALL clear SC7, return to IDLE, and assert irq_serial for exactly the following clock period.
REQ-023 Internal-mode latency SHALL be exactly 8*CLK_DIV clocks from E0 to the irq_serial assertion edge.
REQ-024 During SHIFT, CPU writes to SB SHALL be ignored; SC writes with data_i[7]=1 SHALL be ignored (no restart).
REQ-025 During SHIFT, an SC write with data_i[7]=0 SHALL abort: go IDLE, clear SC7, set sclk_o=1, keep partial SB, no irq_serial.
REQ-026 If an abort write coincides with the 8th-shift edge, the completion SHALL win: shift performed, irq_serial asserted.
REQ-027 A read of SC in the same cycle as completion SHALL return the pre-edge value (SC7=1).
REQ-028 sout SHALL hold its last value in IDLE.

Reset
REQ-029 Reset low SHALL immediately force SB=0x00, SC7=0, SC0=0, state IDLE, counters 0, sclk_o=1, sout=1, irq_serial=0, synchronizer flops=1.
REQ-030 Reset asserted mid-transfer SHALL abandon the transfer with no irq_serial after release.

Verification
REQ-031 CLK_DIV=4, SB=0xA5, sin=1, write SC=0x81 -> sout 1,0,1,0,0,1,0,1 on successive falls; irq_serial one cycle at E0+32; SB=0xFF; SC reads 0x7F.
REQ-032 CLK_DIV=4, SB=0x00, sin=0, start, write SC=0x01 at E0+10 -> IDLE, sclk_o=1, no irq_serial, SC reads 0x7F.
REQ-033 External mode: SB=0x3C, write SC=0x80, 8 sclk_i pulses (6 clk high/low), sin=0 -> irq_serial once, SB=0x00, SC reads 0x7E, sclk_o stays 1.
REQ-034 Internal transfer, write SB=0x55 and SC=0x81 at E0+5 -> both ignored; completion at E0+32 unchanged.
REQ-035 Reset pulse at E0+12 -> all outputs at reset values; no irq_serial for 64 clocks after release.
REQ-036 Read 0xFF01/0xFF02/0xFF00 after reset -> data_o 0x00/0x7E/0xFF, data_oe 1/1/0.
